// File: rtl/a_rom_seq.sv
// Column-range sequencer for the A-matrix coefficient ROM: walks columns, drives
// the registered-read ROM address and streams element pairs over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start, rom_addr holds ptr
// LOAD   | first ROM address issued, data not yet back
// STREAM | pair from rom_data presented, address advances on fire
// DONE   | one-cycle done pulse, then back to IDLE
module a_rom_seq #(
    parameter int ELEM_W = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            cfg_col_first_i,
    input  logic [2:0]            cfg_col_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            rom_addr_o,
    input  logic [2*ELEM_W-1:0]   rom_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ELEM_W-1:0]     out_elem_hi_o,
    output logic [ELEM_W-1:0]     out_elem_lo_o,
    output logic [2:0]            out_row_o,
    output logic [1:0]            out_col_o,
    output logic                  out_col_last_o,
    output logic                  out_last_o
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  beat_q, beat_d;
    logic [2:0]  cnt_sat;
    logic        fire;
    logic        last_beat;

    assign cnt_sat     = (cfg_col_count_i > 3'd4) ? 3'd4 : cfg_col_count_i;
    assign out_valid_o = (state_q == STREAM);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE) && !abort_i;
    assign fire        = out_valid_o && out_ready_i;
    // beat_q counts remaining beats down; terminal count marks the final pair
    assign last_beat   = (beat_q == 5'd0);

    assign out_elem_hi_o  = rom_data_i[2*ELEM_W-1:ELEM_W];
    assign out_elem_lo_o  = rom_data_i[ELEM_W-1:0];
    assign out_row_o      = {ptr_q[1:0], 1'b0};
    assign out_col_o      = ptr_q[3:2];
    assign out_col_last_o = (ptr_q[1:0] == 2'b11);
    assign out_last_o     = out_valid_o && last_beat;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        rom_addr_o = ptr_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    cnt_d = cnt_sat;
                    if (cnt_sat == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = {cfg_col_first_i, 2'b00};
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                beat_d  = {cnt_q, 2'b00} - 5'd1;
                state_d = STREAM;
            end
            STREAM: begin
                // Holding the address on a stall makes the ROM re-read the same word
                if (fire && !last_beat) begin
                    rom_addr_o = ptr_q + 4'd1;
                    beat_d     = beat_q - 5'd1;
                end
                ptr_d = rom_addr_o;
                if (fire && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_q != IDLE && abort_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            cnt_q   <= 3'd0;
            beat_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_a_rom_seq.sv
// Directed bench for a_rom_seq: registered ROM model, scoreboard of expected pairs
// filled at job start and drained on each accepted beat.
module tb_a_rom_seq;
    localparam int EW = 7;

    typedef struct packed {
        logic [3:0]    addr;
        logic [EW-1:0] hi;
        logic [EW-1:0] lo;
        logic [2:0]    row;
        logic [1:0]    col;
        logic          cl;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst, start, abort, out_ready;
    logic [1:0] first;
    logic [2:0] count;
    logic busy, done, out_valid, out_col_last, out_last;
    logic [3:0] rom_addr;
    logic [2*EW-1:0] rom_data;
    logic [EW-1:0] out_hi, out_lo;
    logic [2:0] out_row;
    logic [1:0] out_col;

    beat_t sb[$];
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc_n = 0, beats_job = 0, done_cnt = 0, done_cyc = -1;
    int s_cyc, dcnt0, bp_idx = 0;
    logic busy_s, valid_s, done_s, done_busy;
    logic [3:0] addr_s;
    logic prev_stall = 1'b0;
    logic [20:0] prev_obs;
    logic bp_mode = 1'b0;
    logic [0:5] bp_pat = 6'b100101;

    always #5 clk = ~clk;

    a_rom_seq #(.ELEM_W(EW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .cfg_col_first_i(first), .cfg_col_count_i(count),
        .busy_o(busy), .done_o(done), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_elem_hi_o(out_hi), .out_elem_lo_o(out_lo), .out_row_o(out_row),
        .out_col_o(out_col), .out_col_last_o(out_col_last), .out_last_o(out_last)
    );

    // Column 0 holds (1,2),(3,4),(5,6),(7,8); every other column holds (1,1)
    function automatic logic [2*EW-1:0] rom_word(input logic [3:0] a);
        if (a[3:2] == 2'd0) return {7'(2 * a[1:0] + 1), 7'(2 * a[1:0] + 2)};
        return {7'd1, 7'd1};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beats(input logic [1:0] f, input int nb, input int total);
        beat_t e;
        logic [3:0] a;
        logic [2*EW-1:0] d;
        for (int i = 0; i < nb; i++) begin
            a      = 4'({f, 2'b00} + i);
            d      = rom_word(a);
            e.addr = a;
            e.hi   = d[2*EW-1:EW];
            e.lo   = d[EW-1:0];
            e.row  = {a[1:0], 1'b0};
            e.col  = a[3:2];
            e.cl   = (a[1:0] == 2'd3);
            e.last = (i == total - 1);
            sb.push_back(e);
        end
    endtask

    task automatic sample();
        beat_t e;
        logic [20:0] obs;
        busy_s  = busy;
        valid_s = out_valid;
        done_s  = done;
        addr_s  = rom_addr;
        obs = {out_hi, out_lo, out_row, out_col, out_col_last, out_last};
        if (prev_stall) chk("stall_hold", {out_valid, obs}, {1'b1, prev_obs});
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beats_job++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat", obs, {e.hi, e.lo, e.row, e.col, e.cl, e.last});
                chk("beat_addr", rom_addr, e.last ? e.addr : 4'(e.addr + 1));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc_n;
            done_busy = busy;
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst && !abort;
        prev_obs   = obs;
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc_n++;
        if (bp_mode) begin
            out_ready = bp_pat[bp_idx % 6];
            bp_idx++;
        end
    endtask

    task automatic run_until_done(input int budget);
        logic got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            cyc();
            if (done_s === 1'b1) got = 1'b1;
        end
        chk("done_seen", got, 1);
    endtask

    task automatic begin_job(input logic [1:0] f, input logic [2:0] c);
        first = f; count = c; start = 1'b1; beats_job = 0; s_cyc = cyc_n;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; first = 2'd0; count = 3'd0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_valid", valid_s, 0);
        chk("rst_addr", addr_s, 0);

        // full sweep of all four columns
        push_beats(2'd0, 16, 16);
        begin_job(2'd0, 3'd4);
        cyc();
        chk("load_valid", valid_s, 0);
        chk("load_addr", addr_s, 0);
        chk("load_busy", busy_s, 1);
        run_until_done(40);
        chk("sweep_done_cyc", done_cyc - s_cyc, 18);
        chk("sweep_beats", beats_job, 16);
        chk("sweep_sb_empty", sb.size(), 0);
        cyc();
        chk("sweep_busy_low", busy_s, 0);

        // column wrap 3 -> 0
        push_beats(2'd3, 8, 8);
        begin_job(2'd3, 3'd2);
        cyc();
        chk("wrap_load_addr", addr_s, 12);
        run_until_done(40);
        chk("wrap_done_cyc", done_cyc - s_cyc, 10);
        chk("wrap_beats", beats_job, 8);
        chk("wrap_sb_empty", sb.size(), 0);

        // empty job started in the first IDLE cycle after DONE
        begin_job(2'd0, 3'd0);
        cyc();
        chk("empty_done", done_s, 1);
        chk("empty_done_cyc", done_cyc - s_cyc, 1);
        chk("empty_done_busy", done_busy, 1);
        chk("empty_beats", beats_job, 0);
        cyc();
        chk("empty_busy_low", busy_s, 0);

        // saturated count
        push_beats(2'd0, 16, 16);
        begin_job(2'd0, 3'd7);
        run_until_done(40);
        chk("sat_done_cyc", done_cyc - s_cyc, 18);
        chk("sat_beats", beats_job, 16);
        chk("sat_sb_empty", sb.size(), 0);
        cyc();

        // backpressure
        push_beats(2'd0, 4, 4);
        bp_mode = 1'b1; bp_idx = 0;
        begin_job(2'd0, 3'd1);
        run_until_done(60);
        bp_mode = 1'b0; out_ready = 1'b1;
        chk("bp_beats", beats_job, 4);
        chk("bp_sb_empty", sb.size(), 0);
        cyc();

        // abort on the third beat
        push_beats(2'd0, 3, 16);
        dcnt0 = done_cnt;
        begin_job(2'd0, 3'd4);
        cyc(); cyc(); cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        chk("abort_busy", busy_s, 0);
        chk("abort_valid", valid_s, 0);
        cyc(); cyc();
        chk("abort_no_done", done_cnt, dcnt0);
        chk("abort_beats", beats_job, 3);
        chk("abort_sb_empty", sb.size(), 0);

        push_beats(2'd1, 4, 4);
        begin_job(2'd1, 3'd1);
        run_until_done(30);
        chk("post_abort_done_cyc", done_cyc - s_cyc, 6);
        chk("post_abort_beats", beats_job, 4);
        chk("post_abort_sb_empty", sb.size(), 0);
        cyc();

        // start while busy is ignored
        push_beats(2'd0, 16, 16);
        begin_job(2'd0, 3'd4);
        cyc(); cyc(); cyc();
        first = 2'd2; count = 3'd1; start = 1'b1;
        cyc();
        start = 1'b0; first = 2'd0;
        run_until_done(40);
        chk("busy_start_done_cyc", done_cyc - s_cyc, 18);
        chk("busy_start_beats", beats_job, 16);
        chk("busy_start_sb_empty", sb.size(), 0);
        cyc();

        // synchronous reset mid-stream
        push_beats(2'd2, 3, 8);
        begin_job(2'd2, 3'd2);
        cyc(); cyc(); cyc(); cyc();
        out_ready = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        cyc();
        chk("midrst_busy", busy_s, 0);
        chk("midrst_valid", valid_s, 0);
        chk("midrst_addr", addr_s, 0);
        chk("midrst_done", done_s, 0);
        chk("midrst_beats", beats_job, 3);
        chk("midrst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
